instr_encoder_loader: RTL

//  Converts symbolic LEGv8 instructions (op select + register/immediate fields) into 32-bit machine

---
 rtl/instr_encoder_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic LEGv8 instructions into 32-bit words and streams them into instruction memory.
// Latency: one cycle from accepted beat to wr_en/wr_addr/wr_data; back-to-back beats give back-to-back writes.
// Backpressure: in_ready only in RUN and not during start; a full session, finish, or an error drops in_ready.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter int DEPTH      = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         finish,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   op,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rn,
  input  logic [4:0]                   rm,
  input  logic [25:0]                  imm,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [31:0]                  wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [1:0]                   err_code
);

  localparam int                    CW   = $clog2(DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]         LAST = CW'(DEPTH-1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [31:0]             enc_word;
  logic [1:0]              enc_err;
  logic                    beat;
  logic                    u12_ok, s9_ok, s19_ok;

  // Immediate fit checks: a signed k-bit field needs imm[25:k-1] to be a pure sign extension
  assign u12_ok = (imm[25:12] == 14'd0);
  assign s9_ok  = (&imm[25:8])  | ~(|imm[25:8]);
  assign s19_ok = (&imm[25:18]) | ~(|imm[25:18]);

  assign in_ready = (state == S_RUN) && !start;
  assign beat     = in_valid && in_ready;
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

  // Instruction encoder: builds the machine word and flags illegal ops / immediates that do not fit
  always_comb begin
    enc_word = 32'd0;
    enc_err  = ERR_NONE;
    case (op)
      4'd0:  enc_word = {11'b10001011000, rm, 6'd0, rn, rd};
      4'd2:  enc_word = {11'b10101011000, rm, 6'd0, rn, rd};
      4'd3:  enc_word = {11'b11101011000, rm, 6'd0, rn, rd};
      4'd4:  enc_word = {11'b11001011000, rm, 6'd0, rn, rd};
      4'd1: begin
        enc_word = {10'b1001000100, imm[11:0], rn, rd};
        if (!u12_ok) enc_err = ERR_RANGE;
      end
      4'd5: begin
        enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        if (!s9_ok) enc_err = ERR_RANGE;
      end
      4'd6: begin
        enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        if (!s9_ok) enc_err = ERR_RANGE;
      end
      4'd7:  enc_word = {6'b000101, imm};
      4'd10: enc_word = {6'b100101, imm};
      4'd8: begin
        enc_word = {8'b10110100, imm[18:0], rd};
        if (!s19_ok) enc_err = ERR_RANGE;
      end
      4'd9: begin
        enc_word = {8'b01010100, imm[18:0], 5'b01011};
        if (!s19_ok) enc_err = ERR_RANGE;
      end
      4'd11: enc_word = {11'b11010110000, 5'b11111, 6'd0, rn, 5'd0};
      default: enc_err = ERR_ILLEGAL;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: start restarts from anywhere; RUN ends on error, finish or a full session
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else if (state == S_RUN) begin
      if (beat) begin
        if (enc_err != ERR_NONE)              state_nxt = S_ERR;
        else if (finish || (count == LAST))   state_nxt = S_DONE;
      end else if (finish) begin
        state_nxt = S_DONE;
      end
    end
  end

  // Write port, pointer, word count and error latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= BASE;
      wr_data  <= 32'd0;
      ptr      <= BASE;
      count    <= '0;
      err_code <= ERR_NONE;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        ptr      <= BASE;
        count    <= '0;
        err_code <= ERR_NONE;
      end else if (beat) begin
        if (enc_err != ERR_NONE) begin
          err_code <= enc_err;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= enc_word;
          ptr     <= ptr + ADDR_WIDTH'(4);
          count   <= count + CW'(1);
        end
      end
    end
  end

endmodule
